// File: rtl/mux_arb_nch_pkg.sv
// Shared types and helpers for the N-channel registered mux/arbiter.
// The select width is derived from the channel count and is never overridden.
package mux_arb_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Width of a channel index. A two-channel mux still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_arb_nch_if.sv
// Producer/consumer handshake bundle for mux_arb_nch.
// The master side is the environment and the slave side is the mux.
interface mux_arb_nch_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5
);
  import mux_arb_pkg::*;

  localparam int SEL_W = sel_w(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  mode_e                   mode;
  logic [SEL_W-1:0]        sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid, sel_err
  );

endinterface

// File: rtl/mux_arb_nch_rr.sv
// Round-robin arbiter: grants the first requester after the last granted one.
// The pointer moves only when the caller reports that the grant was consumed.
module rr_arbiter_nch
  import mux_arb_pkg::*;
#(
  parameter int NUM_IN = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN-1:0]            req,
  input  logic                         advance,
  output logic [NUM_IN-1:0]            grant,
  output logic [sel_w(NUM_IN)-1:0]     grantIdx
);

  localparam int SEL_W = sel_w(NUM_IN);

  logic [SEL_W-1:0] rrLastReg;
  logic             found;

  // Walk rrLast+1, rrLast+2, ... modulo NUM_IN; the first request wins.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      int idx;
      idx = (int'(rrLastReg) + k) % NUM_IN;
      if (!found && req[idx]) begin
        found    = 1'b1;
        grantIdx = SEL_W'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_onehot
    assign grant[gi] = found && (grantIdx == SEL_W'(gi));
  end

  // Reset to the last channel so channel 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrLastReg <= SEL_W'(NUM_IN - 1);
    end else if (advance) begin
      rrLastReg <= grantIdx;
    end
  end

endmodule

// File: rtl/mux_arb_nch.sv
// N-channel W-bit registered mux with fixed-select or round-robin grant,
// feeding a one-deep output register with valid/ready on both sides.
module mux_arb_nch
  import mux_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arb_nch_if.slave  bus
);

  localparam int SEL_W = sel_w(NUM_IN);

  logic                  load;
  logic                  selLegal;
  logic                  isRr;
  logic                  transfer;
  logic [NUM_IN-1:0]     fixedGrant;
  logic [NUM_IN-1:0]     rrGrant;
  logic [NUM_IN-1:0]     grant;
  logic [SEL_W-1:0]      rrIdx;
  logic [SEL_W-1:0]      grantIdx;
  logic [WIDTH-1:0]      chanMasked [NUM_IN];
  logic [WIDTH-1:0]      selData;

  logic [WIDTH-1:0]      outDataReg;
  logic [SEL_W-1:0]      outChanReg;
  logic                  outValidReg;
  logic                  selErrReg;

  // The register can accept a word when empty or when its word leaves now.
  assign load     = !outValidReg || bus.out_ready;
  assign isRr     = (bus.mode == MODE_RR);
  assign selLegal = ({1'b0, bus.sel} < (SEL_W + 1)'(NUM_IN));

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_fixed
    assign fixedGrant[gi] = (bus.sel == SEL_W'(gi));
  end

  rr_arbiter_nch #(
    .NUM_IN (NUM_IN)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.in_valid),
    .advance  (transfer && isRr),
    .grant    (rrGrant),
    .grantIdx (rrIdx)
  );

  assign grant        = isRr ? rrGrant : fixedGrant;
  assign grantIdx     = isRr ? rrIdx : bus.sel;
  assign bus.in_ready = load ? grant : '0;
  assign transfer     = |(bus.in_ready & bus.in_valid);

  // One-hot AND-OR select keeps an out-of-range sel from indexing past in_data.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_mask
    assign chanMasked[gi] = bus.in_data[gi*WIDTH +: WIDTH] & {WIDTH{grant[gi]}};
  end

  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      selData = selData | chanMasked[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outDataReg  <= '0;
      outChanReg  <= '0;
      outValidReg <= 1'b0;
      selErrReg   <= 1'b0;
    end else begin
      if (transfer) begin
        outDataReg  <= selData;
        outChanReg  <= grantIdx;
        outValidReg <= 1'b1;
      end else if (load) begin
        outValidReg <= 1'b0;
      end
      selErrReg <= !isRr && !selLegal;
    end
  end

  assign bus.out_data  = outDataReg;
  assign bus.out_chan  = outChanReg;
  assign bus.out_valid = outValidReg;
  assign bus.sel_err   = selErrReg;

endmodule

// File: tb/tb_mux_arb_nch.sv
// Bench for mux_arb_nch (5 channels x 8 bits): directed vector table,
// hand-written backpressure and async-reset sequences, then randomized traffic.
module tb_mux_arb_nch;
  import mux_arb_pkg::*;

  localparam int W  = 8;
  localparam int N  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_arb_nch_if #(.WIDTH(W), .NUM_IN(N)) bus ();

  mux_arb_nch #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    mode_e      mode;
    logic [2:0] sel;
    logic [4:0] valid;
    logic       ordy;
    logic [4:0] expReady;
    logic       expOv;
    logic [7:0] expOd;
    logic [2:0] expOc;
    logic       expErr;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus.mode      = MODE_FIXED;
    bus.sel       = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, outputs after.
  task automatic applyCheck(input string tag, input mode_e m, input logic [2:0] s,
                            input logic [4:0] v, input logic [39:0] d, input logic ordy,
                            input logic [4:0] eR, input logic eOv, input logic [7:0] eOd,
                            input logic [2:0] eOc, input logic eErr);
    bus.mode      = m;
    bus.sel       = s;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    chk({tag, " in_ready"}, 40'(bus.in_ready), 40'(eR));
    @(posedge clk);
    #1;
    chk({tag, " out_valid"}, 40'(bus.out_valid), 40'(eOv));
    chk({tag, " out_data"},  40'(bus.out_data),  40'(eOd));
    chk({tag, " out_chan"},  40'(bus.out_chan),  40'(eOc));
    chk({tag, " sel_err"},   40'(bus.sel_err),   40'(eErr));
    $display("vec %s mode=%0d sel=%0d valid=%b ordy=%b -> ov=%b data=%h chan=%0d err=%b",
             tag, m, s, v, ordy, bus.out_valid, bus.out_data, bus.out_chan, bus.sel_err);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 40'(bus.out_valid), 40'd0);
    chk("reset out_data",  40'(bus.out_data),  40'd0);
    chk("reset out_chan",  40'(bus.out_chan),  40'd0);
    chk("reset sel_err",   40'(bus.sel_err),   40'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [39:0] tData;
    logic [39:0] bpData;
    int          seqA [4];
    // Reference model state for the random phase
    logic        mValid;
    logic [7:0]  mData;
    logic [2:0]  mChan;
    logic        mErr;
    int          mLast;

    tData  = {8'h54, 8'hA5, 8'h32, 8'h21, 8'h10};
    bpData = {8'h54, 8'hA5, 8'h32, 8'h3C, 8'h10};
    seqA   = '{1, 4, 1, 4};

    tbl[0] = '{MODE_FIXED, 3'd3, 5'b01000, 1'b1, 5'b01000, 1'b1, 8'hA5, 3'd3, 1'b0};
    tbl[1] = '{MODE_FIXED, 3'd6, 5'b11111, 1'b1, 5'b00000, 1'b0, 8'hA5, 3'd3, 1'b1};
    tbl[2] = '{MODE_FIXED, 3'd0, 5'b00000, 1'b1, 5'b00001, 1'b0, 8'hA5, 3'd3, 1'b0};
    for (int k = 0; k < 10; k++) begin
      int g;
      g = k % N;
      tbl[3+k] = '{MODE_RR, 3'd0, 5'b11111, 1'b1, 5'(1 << g), 1'b1,
                   tData[g*8 +: 8], 3'(g), 1'b0};
    end
    for (int k = 0; k < 4; k++) begin
      tbl[13+k] = '{MODE_RR, 3'd0, 5'b10010, 1'b1, 5'(1 << seqA[k]), 1'b1,
                    tData[seqA[k]*8 +: 8], 3'(seqA[k]), 1'b0};
    end
    tbl[17] = '{MODE_RR,    3'd0, 5'b00000, 1'b1, 5'b00000, 1'b0, 8'h54, 3'd4, 1'b0};
    tbl[18] = '{MODE_FIXED, 3'd2, 5'b00100, 1'b0, 5'b00100, 1'b1, 8'h32, 3'd2, 1'b0};
    tbl[19] = '{MODE_FIXED, 3'd2, 5'b00100, 1'b0, 5'b00000, 1'b1, 8'h32, 3'd2, 1'b0};
    tbl[20] = '{MODE_FIXED, 3'd2, 5'b00100, 1'b1, 5'b00100, 1'b1, 8'h32, 3'd2, 1'b0};

    doReset();

    for (int i = 0; i < 21; i++) begin
      applyCheck($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].sel, tbl[i].valid, tData,
                 tbl[i].ordy, tbl[i].expReady, tbl[i].expOv, tbl[i].expOd,
                 tbl[i].expOc, tbl[i].expErr);
    end

    // Backpressure: 8'h3C held for three stalled cycles, then swapped with ch2.
    applyCheck("bp_load", MODE_FIXED, 3'd1, 5'b00010, bpData, 1'b1,
               5'b00010, 1'b1, 8'h3C, 3'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyCheck("bp_hold", MODE_FIXED, 3'd2, 5'b00100, bpData, 1'b0,
                 5'b00000, 1'b1, 8'h3C, 3'd1, 1'b0);
    end
    applyCheck("bp_swap", MODE_FIXED, 3'd2, 5'b00100, bpData, 1'b1,
               5'b00100, 1'b1, 8'h32, 3'd2, 1'b0);

    // Async reset between edges while a word is held.
    applyCheck("ar_pre0", MODE_RR, 3'd0, 5'b11111, tData, 1'b1,
               5'b00001, 1'b1, 8'h10, 3'd0, 1'b0);
    applyCheck("ar_pre1", MODE_RR, 3'd0, 5'b11111, tData, 1'b1,
               5'b00010, 1'b1, 8'h21, 3'd1, 1'b0);
    #3;
    rst_n        = 1'b0;
    bus.in_valid = '0;
    #1;
    chk("async out_valid", 40'(bus.out_valid), 40'd0);
    chk("async out_data",  40'(bus.out_data),  40'd0);
    chk("async out_chan",  40'(bus.out_chan),  40'd0);
    #2 rst_n = 1'b1;
    applyCheck("ar_post", MODE_RR, 3'd0, 5'b11111, tData, 1'b1,
               5'b00001, 1'b1, 8'h10, 3'd0, 1'b0);

    // Randomized traffic against a behavioural model.
    doReset();
    mValid = 1'b0;
    mData  = '0;
    mChan  = '0;
    mErr   = 1'b0;
    mLast  = N - 1;
    for (int t = 0; t < 300; t++) begin
      mode_e       m;
      logic [2:0]  s;
      logic [4:0]  v;
      logic [39:0] d;
      logic        ordy;
      logic        canLoad;
      int          g;
      int          cand [$];
      logic [4:0]  eR;

      m    = ($urandom_range(0, 3) == 0) ? MODE_FIXED : MODE_RR;
      s    = 3'($urandom_range(0, 7));
      v    = 5'($urandom);
      d    = {8'($urandom), 32'($urandom)};
      ordy = ($urandom_range(0, 3) != 0);

      canLoad = !mValid || ordy;
      g = -1;
      if (m == MODE_FIXED) begin
        if (int'(s) < N) g = int'(s);
      end else begin
        cand.delete();
        for (int k = 1; k <= N; k++) begin
          if (v[(mLast + k) % N]) cand.push_back((mLast + k) % N);
        end
        if (cand.size() > 0) g = cand[0];
      end
      eR = (canLoad && g >= 0) ? 5'(1 << g) : 5'b0;

      if (canLoad && g >= 0 && v[g]) begin
        mData  = d[g*8 +: 8];
        mChan  = 3'(g);
        mValid = 1'b1;
        if (m == MODE_RR) mLast = g;
      end else if (canLoad) begin
        mValid = 1'b0;
      end
      mErr = (m == MODE_FIXED) && (int'(s) >= N);

      applyCheck($sformatf("rnd%0d", t), m, s, v, d, ordy, eR, mValid, mData, mChan, mErr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
